// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_rows_pipe: registered ShiftRows/InvShiftRows stage, NB=4..8, 2-entry skid
// Optional SHIFT_ROWS_BYPASS_EN adds in_byp (block passes unpermuted). Rev 1.0
// ---------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int NB = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
`ifdef SHIFT_ROWS_BYPASS_EN
    input  logic                in_byp,
`endif
    input  logic [32*NB-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data
);

    localparam int W = 32 * NB;

    // Rijndael row offsets; wider blocks spread rows 2/3 further apart.
    function automatic int row_offset(input int r);
        if (r == 0) return 0;
        if (r == 1) return 1;
        if (r == 2) return (NB == 8) ? 3 : 2;
        return (NB >= 7) ? 4 : 3;
    endfunction

    generate
        if (NB < 4 || NB > 8) begin : g_nb_check
            $error("shift_rows_pipe: NB must be in 4..8");
        end
    endgenerate

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_shifted;
    logic         w_push;
    logic         w_pop;

    generate
        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < NB; c++) begin : g_col
                localparam int SRC_F = (c + row_offset(r)) % NB;
                localparam int SRC_I = (c + NB - row_offset(r)) % NB;
                assign w_fwd[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*SRC_F+r) -: 8];
                assign w_inv[W-1-8*(4*c+r) -: 8] = in_data[W-1-8*(4*SRC_I+r) -: 8];
            end
        end
    endgenerate

`ifdef SHIFT_ROWS_BYPASS_EN
    assign w_shifted = in_byp ? in_data : (in_inv ? w_inv : w_fwd);
`else
    assign w_shifted = in_inv ? w_inv : w_fwd;
`endif

    logic         r_main_valid;
    logic [W-1:0] r_main_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = r_main_valid && out_ready;

    // The skid can only fill while main is full, so an empty main implies an empty skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (clr) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid) begin
            if (w_push) begin
                r_main_data  <= w_shifted;
                r_main_valid <= 1'b1;
            end
        end else if (w_pop) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_push) begin
                r_main_data  <= w_shifted;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_skid_data  <= w_shifted;
            r_skid_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_shift_rows_pipe: scoreboard bench for shift_rows_pipe (NB=4 and NB=8). Rev 1.0
// ---------------------------------------------------------------------------
module tb_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr, in_valid, in_ready, in_inv, in_byp, out_valid, out_ready;
    logic [127:0] in_data, out_data;

    logic         clr8, v8_in, r8_in, inv8, v8_out, r8_out;
    logic [255:0] d8_in, d8_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int n_pop = 0;
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
`ifdef SHIFT_ROWS_BYPASS_EN
        .in_byp(in_byp),
`endif
        .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr8),
        .in_valid(v8_in), .in_ready(r8_in), .in_inv(inv8),
`ifdef SHIFT_ROWS_BYPASS_EN
        .in_byp(1'b0),
`endif
        .in_data(d8_in),
        .out_valid(v8_out), .out_ready(r8_out), .out_data(d8_out)
    );

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference permutation written from the row-offset table, independent of the RTL.
    function automatic logic [255:0] model(input logic [255:0] d, input logic inv, input int nb);
        logic [255:0] res;
        int off[4];
        int w;
        int src;
        res = '0;
        w = 32 * nb;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb >= 7) ? 4 : 3;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
                res[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
            end
        end
        return res;
    endfunction

    // Inputs change #1 after posedge, so negedge sees exactly what the next edge acts on.
    always @(negedge clk) begin
        if (!rst_n || clr) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) check("sb_underflow", 256'd1, 256'd0);
                else check("sb_data", {128'd0, out_data}, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                n_push++;
                exp_q.push_back(in_byp ? {128'd0, in_data} : model({128'd0, in_data}, in_inv, 4));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || out_valid); k++) step();
        check("drain_q_empty", 256'(exp_q.size()), 256'd0);
        check("drain_out_valid", {255'd0, out_valid}, 256'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int p0;
        int q0;
        int sent;
        int cyc;
        int acc_cnt;
        logic acc;
        logic [127:0] blk_a;
        logic [255:0] nb8_src;
        logic [255:0] nb8_fwd;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_byp = 1'b0;
        in_data = '0; out_ready = 1'b0;
        clr8 = 1'b0; v8_in = 1'b0; inv8 = 1'b0; d8_in = '0; r8_out = 1'b1;
        #1;
        check("rst_out_valid", {255'd0, out_valid}, 256'd0);
        check("rst_in_ready", {255'd0, in_ready}, 256'd1);
        check("rst_out_data", {128'd0, out_data}, 256'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // NB=4 forward and inverse known vectors, one cycle after accept
        out_ready = 1'b1;
        in_valid = 1'b1; in_inv = 1'b0; in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
        step();
        in_valid = 1'b0;
        check("fwd_latency", {255'd0, out_valid}, 256'd1);
        check("fwd_vector", {128'd0, out_data}, {128'd0, 128'hd4bf5d30e0b452aeb84111f11e2798e5});
        in_valid = 1'b1; in_inv = 1'b1; in_data = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        step();
        in_valid = 1'b0;
        check("inv_vector", {128'd0, out_data}, {128'd0, 128'hd42711aee0bf98f1b8b45de51e415230});
        drain();

        // Back-pressure: three offered, two stored
        out_ready = 1'b0;
        p0 = n_push; q0 = n_pop;
        blk_a = rnd128();
        in_valid = 1'b1; in_inv = 1'b0; in_data = blk_a;
        step();
        in_data = rnd128(); in_inv = 1'b1;
        step();
        in_data = rnd128(); in_inv = 1'b0;
        step();
        check("bp_in_ready", {255'd0, in_ready}, 256'd0);
        check("bp_accepted", 256'(n_push - p0), 256'd2);
        check("bp_hold_data", {128'd0, out_data}, model({128'd0, blk_a}, 1'b0, 4));
        step();
        check("bp_hold_stable", {128'd0, out_data}, model({128'd0, blk_a}, 1'b0, 4));
        in_valid = 1'b0;
        drain();
        check("bp_popped", 256'(n_pop - q0), 256'd2);

        // Random streaming with random back-pressure
        sent = 0; cyc = 0;
        in_valid = 1'b1; in_data = rnd128(); in_inv = 1'($urandom_range(0, 1));
        while (sent < 100 && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                in_data = rnd128(); in_inv = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        check("stream_sent", 256'(sent), 256'd100);
        drain();

        // Full throughput with out_ready held high
        out_ready = 1'b1; acc_cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = rnd128(); in_inv = 1'($urandom_range(0, 1));
            if (in_ready) acc_cnt++;
            step();
        end
        in_valid = 1'b0;
        check("throughput", 256'(acc_cnt), 256'd20);
        drain();

        // NB=8: row offsets 0/1/3/4
        nb8_src = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        nb8_fwd = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
        v8_in = 1'b1; inv8 = 1'b0; d8_in = nb8_src;
        step();
        v8_in = 1'b0;
        check("nb8_valid", {255'd0, v8_out}, 256'd1);
        check("nb8_fwd", d8_out, nb8_fwd);
        check("nb8_fwd_model", d8_out, model(nb8_src, 1'b0, 8));
        v8_in = 1'b1; inv8 = 1'b1; d8_in = d8_out;
        step();
        v8_in = 1'b0;
        check("nb8_inv_restore", d8_out, nb8_src);

        // clr with both entries held, push in the clr cycle dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = rnd128();
        step();
        in_data = rnd128();
        step();
        check("clr_pre_full", {255'd0, in_ready}, 256'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_out_valid", {255'd0, out_valid}, 256'd0);
        check("clr_in_ready", {255'd0, in_ready}, 256'd1);
        clr = 1'b1; in_data = rnd128();
        step();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_push_dropped", {255'd0, out_valid}, 256'd0);

        // Asynchronous reset mid-burst
        in_valid = 1'b1; in_data = rnd128();
        step();
        in_data = rnd128();
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {255'd0, out_valid}, 256'd0);
        check("arst_in_ready", {255'd0, in_ready}, 256'd1);
        check("arst_out_data", {128'd0, out_data}, 256'd0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_inv = 1'b1; in_data = rnd128();
        step();
        in_valid = 1'b0;
        drain();

`ifdef SHIFT_ROWS_BYPASS_EN
        blk_a = rnd128();
        in_valid = 1'b1; in_byp = 1'b1; in_inv = 1'b1; in_data = blk_a;
        step();
        in_valid = 1'b0; in_byp = 1'b0;
        check("bypass_data", {128'd0, out_data}, {128'd0, blk_a});
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
